gpu_scratchpad: RTL
===================

// Module: gpu_scratchpad
// PURPOSE
//  Dual-port on-chip scratchpad that responds on the GCore data bus (addr/sel/we/data/ready).
//  Serves the master and slave GCores through one shared single-port 48-bit word memory,
//  using round-robin arbitration. It is intended as a low-latency alternative to the
//  external SRAM for shared GPU state, and is mapped by the address decoder next to the sram and cpg.
// PARAMETERS
//  ADDR_W   8   word-address bits used; memory depth = 2**ADDR_W words of 48 bits
//  DATA_W  48   data word width; must match the GCore data bus
// PORTS
//  clk           in   1       system clock
//  rst           in   1       asynchronous reset, active-high
//  addr_0        in   20      port-0 (master) word address; only [ADDR_W-1:0] used
//  data_in_0     in   DATA_W  port-0 write data
//  data_sel_0    in   1       port-0 request (read or write), held until data_ready_0
//  data_we_0     in   1       port-0 write qualifier, valid while data_sel_0 is high
//  data_out_0    out  DATA_W  port-0 read data, valid in the data_ready_0 cycle
//  data_ready_0  out  1       port-0 completion pulse (1 cycle)
//  addr_1 .. data_ready_1     same six signals for port 1 (slave)
//  acc_cnt_0     out  16      port-0 completed-access count (see CONFIGURATION)
//  acc_cnt_1     out  16      port-1 completed-access count
// BEHAVIOUR
//  - Reset values: data_ready_x=0, data_out_x=0, acc_cnt_x=0, FSM=IDLE, rr_last=1 (port 0 wins first tie).
//    Memory contents are not reset.
//  - FSM has three states: IDLE -> ACCESS -> DONE -> IDLE.
//    IDLE: if any data_sel_x is high, latch the granted port's addr/we/data and go to ACCESS.
//    ACCESS: perform the memory op. A write commits at the end of this cycle; a read captures the word.
//    DONE: data_ready_g=1 for exactly one cycle. On a read, data_out_g holds the word; on a write, it holds the written word.
//  - Latency is 3 cycles from a sel sampled in IDLE to ready. Back-to-back throughput is one access per 3 cycles.
//  - Arbitration: if one port requests, it is granted. If both request, the port != rr_last wins.
//    rr_last updates on each grant. No starvation: the losing port is granted next.
//  - A request is sampled only in IDLE. The cycle after DONE is IDLE, so a sel still high then
//    (a new request from the initiator) is a new access.
//  - data_out_x holds its value until that port's next DONE. The ungranted port's ready stays 0.
//  - Address wrap: bits above ADDR_W-1 are ignored, e.g. with ADDR_W=8, addr 0x00105 aliases 0x05.
//  - If sel drops during ACCESS (protocol violation), the access still completes.
//    Ready still pulses, and a write still commits.
//  - Reset asserted mid-operation: the FSM returns to IDLE and any pending ready is suppressed.
//    A write commits only if the ACCESS-cycle edge occurred before rst asserted.
//  - Same address from both ports: the accesses are serialized in grant order.
//    A read granted after a write returns the new data.
// CONFIGURATION
//  GPU_SCRATCHPAD_STATS_EN defined:
//    acc_cnt_x increments by 1 on every DONE cycle for port x and wraps 0xFFFF->0x0000. Reset clears it.
//  Not defined:
//    acc_cnt_0 and acc_cnt_1 are constant 0 and no counter flops are synthesized.
// TESTING
//  1. Port 0 write addr 0x10 data 0x123456789ABC, then read 0x10 -> data_ready_0 3 cycles after each sel;
//     read returns 0x123456789ABC.
//  2. Both sel high in the same IDLE cycle after reset -> port 0 is served first, then port 1.
//     Ready pulses occur 3 cycles apart; neither port is starved over 10 repeats.
//  3. Port 1 writes 0xAAAA_5555_0F0F to addr 0x105 with ADDR_W=8; port 0 then reads 0x05 -> 0xAAAA55550F0F.
//  4. Assert rst during ACCESS of a port-0 write to a previously written address -> no ready pulse;
//     outputs are 0; the later read returns either the old or the new word per edge timing.
//     The bench checks that its prediction matches.
//  5. Port 0 holds sel continuously for 4 reads -> exactly 4 one-cycle ready pulses, 3 cycles apart.
//  6. With GPU_SCRATCHPAD_STATS_EN: 3 accesses on port 0 and 2 on port 1 -> acc_cnt_0=3, acc_cnt_1=2.
//     Without the macro, both counters read 0.

Source files
------------

// File: rtl/gpu_scratchpad_if.sv
// GCore data-bus port bundle for gpu_scratchpad.
// master: the GCore issuing requests; slave: the scratchpad answering them.
interface gpu_scratchpad_if #(
    parameter int DATA_W = 48
);
    logic [19:0]       addr;
    logic [DATA_W-1:0] data_in;
    logic              data_sel;
    logic              data_we;
    logic [DATA_W-1:0] data_out;
    logic              data_ready;

    modport master (
        output addr, data_in, data_sel, data_we,
        input  data_out, data_ready
    );

    modport slave (
        input  addr, data_in, data_sel, data_we,
        output data_out, data_ready
    );
endinterface

// File: rtl/gpu_scratchpad.sv
// gpu_scratchpad: two GCore bus ports (0 = master core, 1 = slave core) sharing one
// single-port 48-bit word memory. Round-robin arbitration, three-state access FSM
// (IDLE -> ACCESS -> DONE), one access per three cycles.
// Optional per-port completed-access counters: define GPU_SCRATCHPAD_STATS_EN.
module gpu_scratchpad #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 48
) (
    input  logic              clk,
    input  logic              rst,
    gpu_scratchpad_if.slave   port_0,
    gpu_scratchpad_if.slave   port_1,
    output logic [15:0]       acc_cnt_0,
    output logic [15:0]       acc_cnt_1
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Per-port views of the two bus bundles so the per-port logic can be generated.
    logic [1:0]        sel;
    logic [1:0]        we_in;
    logic [19:0]       addr_in [2];
    logic [DATA_W-1:0] data_in [2];
    logic [DATA_W-1:0] data_out [2];
    logic [1:0]        done_hit;
    logic [1:0][15:0]  acc_cnt;

    assign sel        = {port_1.data_sel, port_0.data_sel};
    assign we_in      = {port_1.data_we,  port_0.data_we};
    assign addr_in[0] = port_0.addr;
    assign addr_in[1] = port_1.addr;
    assign data_in[0] = port_0.data_in;
    assign data_in[1] = port_1.data_in;

    assign port_0.data_out   = data_out[0];
    assign port_1.data_out   = data_out[1];
    assign port_0.data_ready = done_hit[0];
    assign port_1.data_ready = done_hit[1];
    assign acc_cnt_0         = acc_cnt[0];
    assign acc_cnt_1         = acc_cnt[1];

    // Upper address bits are deliberately ignored: the scratchpad aliases across its window.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{port_0.addr[19:ADDR_W], port_1.addr[19:ADDR_W]};

    state_t            state_reg, state_next;
    logic              grant_reg, grant_next;
    logic              rr_last_reg;
    logic              load;
    logic [ADDR_W-1:0] lat_addr_reg;
    logic              lat_we_reg;
    logic [DATA_W-1:0] lat_data_reg;
    logic [DATA_W-1:0] rd_word_reg;
    logic [DATA_W-1:0] done_word;

    logic [19:0]       pick_addr;
    logic [DATA_W-1:0] pick_data;
    logic              pick_we;

    // Next-state and arbitration: requests are only considered while IDLE.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|sel) begin
                    load       = 1'b1;
                    state_next = ACCESS;
                    // Single requester wins outright; on a tie the port that did not win last goes.
                    grant_next = (sel == 2'b11) ? ~rr_last_reg : sel[1];
                end
            end
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign pick_addr = grant_next ? addr_in[1] : addr_in[0];
    assign pick_data = grant_next ? data_in[1] : data_in[0];
    assign pick_we   = grant_next ? we_in[1]   : we_in[0];

    // FSM state, grant bookkeeping and request latch; the latch decouples the access from sel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            grant_reg    <= 1'b0;
            rr_last_reg  <= 1'b1;
            lat_addr_reg <= '0;
            lat_we_reg   <= 1'b0;
            lat_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            if (load) begin
                rr_last_reg  <= grant_next;
                lat_addr_reg <= pick_addr[ADDR_W-1:0];
                lat_we_reg   <= pick_we;
                lat_data_reg <= pick_data;
            end
        end
    end

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Word memory with registered read; a write commits only on the edge that ends ACCESS,
    // so an asynchronous reset before that edge (state forced to IDLE) cancels it.
    always_ff @(posedge clk) begin
        if (state_reg == ACCESS && lat_we_reg) begin
            mem[lat_addr_reg] <= lat_data_reg;
        end
        rd_word_reg <= mem[lat_addr_reg];
    end

    // A write reports the word it wrote; a read reports the word captured at the ACCESS edge.
    assign done_word = lat_we_reg ? lat_data_reg : rd_word_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_port
            logic [DATA_W-1:0] hold_reg;

            assign done_hit[gi] = (state_reg == DONE) && (grant_reg == 1'(gi));
            // In DONE the fresh word is passed straight through; afterwards the copy is held.
            assign data_out[gi] = done_hit[gi] ? done_word : hold_reg;

            // Keep the last completed word for this port until its next DONE.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_reg <= '0;
                end else if (done_hit[gi]) begin
                    hold_reg <= done_word;
                end
            end

`ifdef GPU_SCRATCHPAD_STATS_EN
            logic [15:0] cnt_reg;

            // Completed-access counter, wraps naturally at 16 bits.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (done_hit[gi]) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end

            assign acc_cnt[gi] = cnt_reg;
`else
            assign acc_cnt[gi] = '0;
`endif
        end
    endgenerate

endmodule
